// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and types for the float frame buffer
package audio_pkg;

  localparam int N        = 1024;
  localparam int P        = 10;
  localparam int FP_WIDTH = 32;

  typedef logic [FP_WIDTH-1:0] float_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port RAM, one write port, one registered read port
module frame_ram #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write when enabled; read address is registered into rdata every cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/float_frame_buffer.sv
// rtl/float_frame_buffer.sv - ping-pong frame buffer from converter samples to the FFT stream
module float_frame_buffer
  import audio_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  float_t       in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output float_t       out_data,
  output logic [P-1:0] out_index,
  output logic         out_last,
  output logic         frame_start,
  output logic         overflow
);

  logic         wr_bank;
  logic [P-1:0] wr_ptr;
  logic [1:0]   bank_full;
  logic [1:0]   bank_full_next;
  logic         rd_bank;
  logic [P-1:0] rd_ptr;
  rd_state_t    rd_state;
  logic         rd_issue;
  logic [P-1:0] rd_addr_ptr;
  logic         rd_pending;
  float_t       hold_q;
  float_t       ram_rdata;
  logic         wr_accept;
  logic         wr_fill;
  logic         rd_fire;
  logic         rd_release;

  // Flags are the registered values, so a release and a write to the same bank
  // in one cycle still sees the bank as full and drops the sample.
  assign wr_accept  = in_valid && !bank_full[wr_bank];
  assign wr_fill    = wr_accept && (wr_ptr == P'(N - 1));
  assign rd_fire    = out_valid && out_ready;
  assign rd_release = rd_fire && out_last;

  assign out_valid = (rd_state == RD_STREAM);
  assign out_index = rd_ptr;
  assign out_last  = out_valid && (rd_ptr == P'(N - 1));
  // Fresh RAM data the cycle after a read, otherwise the held copy
  assign out_data  = rd_pending ? ram_rdata : hold_q;

  frame_ram #(
    .AW(P + 1),
    .DW(FP_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_accept),
    .waddr({wr_bank, wr_ptr}),
    .wdata(in_data),
    .raddr({rd_bank, rd_addr_ptr}),
    .rdata(ram_rdata)
  );

  // Read address: word 0 on FETCH, next word on each non-final handshake
  always_comb begin
    rd_issue    = 1'b0;
    rd_addr_ptr = rd_ptr;
    if (rd_state == RD_FETCH) begin
      rd_issue    = 1'b1;
      rd_addr_ptr = '0;
    end else if (rd_state == RD_STREAM && rd_fire && !out_last) begin
      rd_issue    = 1'b1;
      rd_addr_ptr = rd_ptr + 1'b1;
    end
  end

  // Bank ownership: reader clears its bank, writer sets the bank it just filled
  always_comb begin
    bank_full_next = bank_full;
    if (rd_release) bank_full_next[rd_bank] = 1'b0;
    if (wr_fill)    bank_full_next[wr_bank] = 1'b1;
  end

  // Write side: pointer, bank toggle, frame_start pulse, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      wr_ptr      <= '0;
      bank_full   <= 2'b00;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      bank_full   <= bank_full_next;
      frame_start <= wr_fill;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (wr_fill) wr_bank <= ~wr_bank;
      if (in_valid && bank_full[wr_bank]) overflow <= 1'b1;
    end
  end

  // Read FSM: wait for a full bank, prefetch word 0, stream to the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_issue;
      case (rd_state)
        RD_IDLE: begin
          if (bank_full[rd_bank]) rd_state <= RD_FETCH;
        end
        RD_FETCH: begin
          rd_state <= RD_STREAM;
        end
        RD_STREAM: begin
          if (rd_fire) begin
            if (out_last) begin
              rd_bank  <= ~rd_bank;
              rd_ptr   <= '0;
              rd_state <= bank_full[~rd_bank] ? RD_FETCH : RD_IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Holding register keeps the presented word stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= out_data;
  end

endmodule

// File: tb/tb_float_frame_buffer.sv
// tb/tb_float_frame_buffer.sv - scoreboard bench for float_frame_buffer
module tb_float_frame_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  out_index;
  logic        out_last;
  logic        frame_start;
  logic        overflow;

  typedef struct packed {
    logic [31:0] data;
    logic [9:0]  index;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_ptr = 0;

  float_frame_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_start(frame_start),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] to_float(input int v);
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    e = 0;
    for (int b = 0; b < 24; b++) if (v[b]) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Drive count consecutive samples base.. and record what the reader must emit
  task automatic send(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_data  = to_float(base + i);
      sb_q.push_back('{data: to_float(base + i), index: 10'(model_ptr), last: (model_ptr == 1023)});
      model_ptr = (model_ptr + 1) % 1024;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // One sample that the design must drop; nothing expected from it
  task automatic send_dropped(input int v);
    in_valid = 1'b1;
    in_data  = to_float(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((sb_q.size() != 0 || out_valid) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_word(input string name, input int idx, input int budget);
    int c = 0;
    while (!(out_valid && out_index == 10'(idx)) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 64'(out_valid && out_index == 10'(idx)), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    model_ptr = 0;
  endtask

  // Monitor: every presented word must match the head of the scoreboard;
  // the head is popped only on a handshake, so stalls re-check the same word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got data=%h idx=%0d with nothing expected", out_data, out_index);
      end else begin
        e = sb_q[0];
        if (out_data !== e.data || out_index !== e.index || out_last !== e.last) begin
          n_err++;
          $display("FAIL word: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                   out_data, out_index, out_last, e.data, e.index, e.last);
        end
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, out_data, out_index, out_last, frame_start, overflow}, 64'd0);
    rst = 1'b0;

    // 1. continuous fill, frame_start and out_valid latency
    out_ready = 1'b1;
    send(0, 1024);
    @(negedge clk);
    check("t1_frame_start_pulse", {frame_start, out_valid}, 64'b10);
    @(negedge clk);
    check("t1_fetch_cycle", {frame_start, out_valid}, 64'b00);
    @(negedge clk);
    check("t1_first_word", {out_valid, out_index}, {1'b1, 10'd0});
    @(posedge clk); #1;
    wait_drain("t1_drain", 3000);
    check("t1_overflow", 64'(overflow), 64'd0);

    // 2. backpressure with out_ready pattern 1,0,0,1
    fork
      send(4096, 1024);
      begin
        for (int c = 0; c < 3300; c++) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("t2_drain", 3000);

    // 3. overlap: frame B written while frame A streams, one idle cycle between
    send(6000, 1024);
    fork
      send(2048, 1024);
      begin
        int c = 0;
        @(negedge clk);
        while (!(out_valid && out_ready && out_last) && c < 3000) begin
          @(negedge clk);
          c++;
        end
        check("t3_a_last_seen", 64'(out_valid && out_last), 64'd1);
        @(negedge clk);
        check("t3_gap_idle", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t3_b_first", {out_valid, out_index}, {1'b1, 10'd0});
      end
    join
    wait_drain("t3_drain", 3000);

    // 4. overflow with both banks held full
    out_ready = 1'b0;
    send(0, 2048);
    check("t4_no_overflow_yet", 64'(overflow), 64'd0);
    send_dropped(2048);
    check("t4_overflow_set", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    wait_drain("t4_drain", 5000);

    // 5. release of bank 0 collides with a write targeting bank 0
    do_reset();
    check("t5_overflow_cleared", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    send(10000, 2048);
    check("t5_no_overflow_yet", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_word("t5_reach_last", 1023, 3000);
    send_dropped(777);
    check("t5_collision_overflow", 64'(overflow), 64'd1);
    wait_drain("t5_drain", 3000);

    // 6. reset in the middle of a stream
    send(300, 1024);
    wait_word("t6_reach_500", 500, 3000);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_after_reset", {out_valid, overflow, frame_start, out_index}, 64'd0);
    sb_q.delete();
    model_ptr = 0;
    rst       = 1'b0;
    out_ready = 1'b1;
    send(5000, 1024);
    wait_drain("t6_drain", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
